execute_stage: RTL and testbench

Execute stage of the five-stage RISC-V pipeline. It holds the ID/EX pipeline register, which captures the decoded operands and the 3-bit ALU control word produced by the ALU decoder. It applies hazard-unit forwarding, computes the ALU result and zero flag, and registers the result into the EX/MEM pipeline register for the memory stage. The stall and flush controls from the hazard unit act on the ID/EX register.

---
 rtl/execute_stage.sv | 173 +++++++++++++++++
 tb/tb_execute_stage.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// Execute stage: ID/EX pipeline register, forwarding muxes, ALU with zero
// flag, and the EX/MEM pipeline register feeding the memory stage.
module execute_stage #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall_e,
   input  logic             flush_e,
   input  logic [WIDTH-1:0] rd1_d,
   input  logic [WIDTH-1:0] rd2_d,
   input  logic [WIDTH-1:0] imm_ext_d,
   input  logic [4:0]       rd_d,
   input  logic [2:0]       alu_ctrl_d,
   input  logic             alu_src_d,
   input  logic             reg_write_d,
   input  logic             mem_write_d,
   input  logic [1:0]       forward_a_e,
   input  logic [1:0]       forward_b_e,
   input  logic [WIDTH-1:0] result_w,
   output logic             zero_e,
   output logic [WIDTH-1:0] alu_result_m,
   output logic [WIDTH-1:0] write_data_m,
   output logic [4:0]       rd_m,
   output logic             reg_write_m,
   output logic             mem_write_m
);

   localparam int unsigned REG_IDX_W = 5;
   localparam int unsigned CTRL_W    = 3;
   localparam int unsigned FWD_W     = 2;

   // ALU control encodings from the ALU decoder
   localparam logic [CTRL_W-1:0] ALU_ADD = 3'b010;
   localparam logic [CTRL_W-1:0] ALU_SUB = 3'b110;
   localparam logic [CTRL_W-1:0] ALU_SLT = 3'b111;
   localparam logic [CTRL_W-1:0] ALU_OR  = 3'b001;
   localparam logic [CTRL_W-1:0] ALU_AND = 3'b000;

   // Forwarding selects from the hazard unit; 11 falls back to the register value
   localparam logic [FWD_W-1:0] FWD_MEM = 2'b10;
   localparam logic [FWD_W-1:0] FWD_WB  = 2'b01;

   // ID/EX pipeline register payload
   typedef struct packed {
      logic [WIDTH-1:0]     rd1;
      logic [WIDTH-1:0]     rd2;
      logic [WIDTH-1:0]     imm_ext;
      logic [REG_IDX_W-1:0] rd;
      logic [CTRL_W-1:0]    alu_ctrl;
      logic                 alu_src;
      logic                 reg_write;
      logic                 mem_write;
   } id_ex_t;

   // EX/MEM pipeline register payload
   typedef struct packed {
      logic [WIDTH-1:0]     alu_result;
      logic [WIDTH-1:0]     write_data;
      logic [REG_IDX_W-1:0] rd;
      logic                 reg_write;
      logic                 mem_write;
   } ex_mem_t;

   id_ex_t           id_ex_q;
   id_ex_t           id_ex_load;
   ex_mem_t          ex_mem_q;
   ex_mem_t          ex_mem_load;

   logic [WIDTH-1:0] src_a;
   logic [WIDTH-1:0] fwd_b;
   logic [WIDTH-1:0] src_b;
   logic [WIDTH-1:0] alu_result;
   logic             slt_lt;

   // Gather decode-stage inputs into the ID/EX payload
   always_comb begin
      id_ex_load           = '0;
      id_ex_load.rd1       = rd1_d;
      id_ex_load.rd2       = rd2_d;
      id_ex_load.imm_ext   = imm_ext_d;
      id_ex_load.rd        = rd_d;
      id_ex_load.alu_ctrl  = alu_ctrl_d;
      id_ex_load.alu_src   = alu_src_d;
      id_ex_load.reg_write = reg_write_d;
      id_ex_load.mem_write = mem_write_d;
   end

   // ID/EX register: flush loads an all-zero bubble ("and 0,0", no writes), stall holds
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         id_ex_q <= '0;
      end else if (flush_e) begin
         id_ex_q <= '0;
      end else if (!stall_e) begin
         id_ex_q <= id_ex_load;
      end
   end

   // Operand A forwarding mux
   always_comb begin
      src_a = id_ex_q.rd1;
      case (forward_a_e)
         FWD_MEM: src_a = ex_mem_q.alu_result;
         FWD_WB:  src_a = result_w;
         default: src_a = id_ex_q.rd1;
      endcase
   end

   // Operand B forwarding mux; the forwarded value is also the store data
   always_comb begin
      fwd_b = id_ex_q.rd2;
      case (forward_b_e)
         FWD_MEM: fwd_b = ex_mem_q.alu_result;
         FWD_WB:  fwd_b = result_w;
         default: fwd_b = id_ex_q.rd2;
      endcase
   end

   // Operand B source select: immediate or forwarded register
   always_comb begin
      src_b = fwd_b;
      if (id_ex_q.alu_src) begin
         src_b = id_ex_q.imm_ext;
      end
   end

   // ALU; arithmetic wraps modulo 2^WIDTH, unused encodings produce 0
   always_comb begin
      alu_result = '0;
      slt_lt     = ($signed(src_a) < $signed(src_b));
      case (id_ex_q.alu_ctrl)
         ALU_ADD: alu_result = src_a + src_b;
         ALU_SUB: alu_result = src_a - src_b;
         ALU_SLT: alu_result = WIDTH'(slt_lt);
         ALU_OR:  alu_result = src_a | src_b;
         ALU_AND: alu_result = src_a & src_b;
         default: alu_result = '0;
      endcase
   end

   // Branch-resolution zero flag, same cycle as the ALU
   assign zero_e = (alu_result == '0);

   // Gather EX results into the EX/MEM payload
   always_comb begin
      ex_mem_load            = '0;
      ex_mem_load.alu_result = alu_result;
      ex_mem_load.write_data = fwd_b;
      ex_mem_load.rd         = id_ex_q.rd;
      ex_mem_load.reg_write  = id_ex_q.reg_write;
      ex_mem_load.mem_write  = id_ex_q.mem_write;
   end

   // EX/MEM register: a stall inserts a bubble so the held instruction issues only once
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ex_mem_q <= '0;
      end else if (stall_e) begin
         ex_mem_q <= '0;
      end else begin
         ex_mem_q <= ex_mem_load;
      end
   end

   // Registered outputs to the memory stage
   assign alu_result_m = ex_mem_q.alu_result;
   assign write_data_m = ex_mem_q.write_data;
   assign rd_m         = ex_mem_q.rd;
   assign reg_write_m  = ex_mem_q.reg_write;
   assign mem_write_m  = ex_mem_q.mem_write;

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed scenarios plus randomized
// traffic against an instruction-level reference model.
module tb_execute_stage;

   logic        clk;
   logic        reset;
   logic        stall_e;
   logic        flush_e;
   logic [31:0] rd1_d;
   logic [31:0] rd2_d;
   logic [31:0] imm_ext_d;
   logic [4:0]  rd_d;
   logic [2:0]  alu_ctrl_d;
   logic        alu_src_d;
   logic        reg_write_d;
   logic        mem_write_d;
   logic [1:0]  forward_a_e;
   logic [1:0]  forward_b_e;
   logic [31:0] result_w;
   logic        zero_e;
   logic [31:0] alu_result_m;
   logic [31:0] write_data_m;
   logic [4:0]  rd_m;
   logic        reg_write_m;
   logic        mem_write_m;

   int n_checks = 0;
   int n_fail   = 0;

   execute_stage #(.WIDTH(32)) dut (
      .clk          (clk),
      .reset        (reset),
      .stall_e      (stall_e),
      .flush_e      (flush_e),
      .rd1_d        (rd1_d),
      .rd2_d        (rd2_d),
      .imm_ext_d    (imm_ext_d),
      .rd_d         (rd_d),
      .alu_ctrl_d   (alu_ctrl_d),
      .alu_src_d    (alu_src_d),
      .reg_write_d  (reg_write_d),
      .mem_write_d  (mem_write_d),
      .forward_a_e  (forward_a_e),
      .forward_b_e  (forward_b_e),
      .result_w     (result_w),
      .zero_e       (zero_e),
      .alu_result_m (alu_result_m),
      .write_data_m (write_data_m),
      .rd_m         (rd_m),
      .reg_write_m  (reg_write_m),
      .mem_write_m  (mem_write_m)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: the instruction sitting in EX, and the retired EX/MEM record
   typedef struct {
      logic [31:0] rd1, rd2, imm;
      logic [4:0]  rd;
      logic [2:0]  ctrl;
      logic        src, rw, mw;
   } instr_t;

   instr_t      ex_q;
   logic [31:0] m_res, m_wd;
   logic [4:0]  m_rd;
   logic        m_rw, m_mw;

   function automatic logic [31:0] ref_alu(input logic [2:0] ctrl, input logic [31:0] a, input logic [31:0] b);
      case (ctrl)
         3'b010:  return a + b;
         3'b110:  return a - b;
         3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         3'b001:  return a | b;
         3'b000:  return a & b;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] regv,
                                        input logic [31:0] memv, input logic [31:0] wbv);
      if (sel == 2'b10) return memv;
      if (sel == 2'b01) return wbv;
      return regv;
   endfunction

   function automatic logic [31:0] model_fwd_b();
      return pick(forward_b_e, ex_q.rd2, m_res, result_w);
   endfunction

   function automatic logic [31:0] model_alu();
      logic [31:0] a, b;
      a = pick(forward_a_e, ex_q.rd1, m_res, result_w);
      b = ex_q.src ? ex_q.imm : model_fwd_b();
      return ref_alu(ex_q.ctrl, a, b);
   endfunction

   task automatic model_clear();
      ex_q  = '{default: '0};
      m_res = '0; m_wd = '0; m_rd = '0; m_rw = 1'b0; m_mw = 1'b0;
   endtask

   task automatic set_d(input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                        input logic [4:0] rd, input logic [2:0] ctrl, input logic src,
                        input logic rw, input logic mw);
      rd1_d = a; rd2_d = b; imm_ext_d = imm; rd_d = rd; alu_ctrl_d = ctrl;
      alu_src_d = src; reg_write_d = rw; mem_write_d = mw;
   endtask

   task automatic set_nop();
      set_d('0, '0, '0, '0, 3'b000, 1'b0, 1'b0, 1'b0);
   endtask

   // Advance one clock, updating the model from the inputs seen before the edge
   task automatic tick();
      instr_t      nxt;
      logic [31:0] r, wd;
      r  = model_alu();
      wd = model_fwd_b();
      nxt.rd1 = rd1_d; nxt.rd2 = rd2_d; nxt.imm = imm_ext_d; nxt.rd = rd_d;
      nxt.ctrl = alu_ctrl_d; nxt.src = alu_src_d; nxt.rw = reg_write_d; nxt.mw = mem_write_d;
      @(posedge clk);
      #1;
      if (reset) begin
         model_clear();
      end else begin
         if (stall_e) begin
            m_res = '0; m_wd = '0; m_rd = '0; m_rw = 1'b0; m_mw = 1'b0;
         end else begin
            m_res = r; m_wd = wd; m_rd = ex_q.rd; m_rw = ex_q.rw; m_mw = ex_q.mw;
         end
         if (flush_e)       ex_q = '{default: '0};
         else if (!stall_e) ex_q = nxt;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; stall_e = 1'b0; flush_e = 1'b0;
      forward_a_e = 2'b00; forward_b_e = 2'b00; result_w = '0;
      set_d(32'h1234, 32'h5678, 32'h9, 5'd7, 3'b010, 1'b0, 1'b1, 1'b1);
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (alu_result_m !== 32'd0) begin n_fail++; $display("FAIL reset_alu_result got=%h exp=0", alu_result_m); end
      n_checks++; if (write_data_m !== 32'd0) begin n_fail++; $display("FAIL reset_write_data got=%h exp=0", write_data_m); end
      n_checks++; if (rd_m !== 5'd0) begin n_fail++; $display("FAIL reset_rd got=%0d exp=0", rd_m); end
      n_checks++; if ({reg_write_m, mem_write_m} !== 2'b00) begin n_fail++; $display("FAIL reset_ctrl got=%b exp=00", {reg_write_m, mem_write_m}); end
      n_checks++; if (zero_e !== 1'b1) begin n_fail++; $display("FAIL reset_zero got=%b exp=1", zero_e); end
      set_nop();
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_sub();
      set_d(32'd5, 32'd7, 32'd0, 5'd3, 3'b110, 1'b0, 1'b1, 1'b0);
      tick();
      set_nop();
      #1;
      n_checks++; if (zero_e !== 1'b0) begin n_fail++; $display("FAIL sub_zero got=%b exp=0", zero_e); end
      tick();
      n_checks++; if (alu_result_m !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL sub_result got=%h exp=fffffffe", alu_result_m); end
      n_checks++; if (rd_m !== 5'd3) begin n_fail++; $display("FAIL sub_rd got=%0d exp=3", rd_m); end
      n_checks++; if (reg_write_m !== 1'b1) begin n_fail++; $display("FAIL sub_reg_write got=%b exp=1", reg_write_m); end
   endtask

   task automatic test_logic();
      set_d(32'hFFFF_FFFF, 32'd1, '0, 5'd1, 3'b111, 1'b0, 1'b1, 1'b0);
      tick();
      set_d(32'hFFFF_FFFF, 32'd1, '0, 5'd2, 3'b000, 1'b0, 1'b1, 1'b0);
      tick();
      n_checks++; if (alu_result_m !== 32'd1) begin n_fail++; $display("FAIL slt_result got=%h exp=1", alu_result_m); end
      set_d(32'hFFFF_FFFF, 32'd1, '0, 5'd4, 3'b001, 1'b0, 1'b1, 1'b0);
      tick();
      n_checks++; if (alu_result_m !== 32'd1) begin n_fail++; $display("FAIL and_result got=%h exp=1", alu_result_m); end
      set_nop();
      tick();
      n_checks++; if (alu_result_m !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL or_result got=%h exp=ffffffff", alu_result_m); end
      n_checks++; if (rd_m !== 5'd4) begin n_fail++; $display("FAIL or_rd got=%0d exp=4", rd_m); end
   endtask

   task automatic test_forward();
      set_d(32'd3, 32'd7, '0, 5'd5, 3'b010, 1'b0, 1'b1, 1'b0);
      tick();
      set_d(32'd0, 32'd0, 32'd4, 5'd6, 3'b010, 1'b1, 1'b1, 1'b0);
      tick();
      forward_a_e = 2'b10;
      set_nop();
      #1;
      n_checks++; if (alu_result_m !== 32'd10) begin n_fail++; $display("FAIL fwd_producer got=%h exp=a", alu_result_m); end
      tick();
      forward_a_e = 2'b00;
      n_checks++; if (alu_result_m !== 32'd14) begin n_fail++; $display("FAIL fwd_a_mem got=%h exp=e", alu_result_m); end
      set_d(32'd1, 32'd0, 32'd0, 5'd7, 3'b010, 1'b0, 1'b1, 1'b0);
      tick();
      forward_b_e = 2'b01; result_w = 32'd9;
      set_nop();
      tick();
      forward_b_e = 2'b00; result_w = '0;
      n_checks++; if (alu_result_m !== 32'd10) begin n_fail++; $display("FAIL fwd_b_wb_result got=%h exp=a", alu_result_m); end
      n_checks++; if (write_data_m !== 32'd9) begin n_fail++; $display("FAIL fwd_b_wb_store got=%h exp=9", write_data_m); end
   endtask

   task automatic test_stall();
      set_d(32'd20, 32'd22, '0, 5'd8, 3'b010, 1'b0, 1'b0, 1'b1);
      tick();
      stall_e = 1'b1;
      set_d(32'd100, 32'd100, '0, 5'd9, 3'b010, 1'b0, 1'b1, 1'b1);
      for (int k = 0; k < 2; k++) begin
         tick();
         n_checks++; if (mem_write_m !== 1'b0) begin n_fail++; $display("FAIL stall_bubble%0d got=%b exp=0", k, mem_write_m); end
      end
      stall_e = 1'b0;
      set_nop();
      tick();
      n_checks++; if (mem_write_m !== 1'b1) begin n_fail++; $display("FAIL stall_issue got=%b exp=1", mem_write_m); end
      n_checks++; if (alu_result_m !== 32'd42) begin n_fail++; $display("FAIL stall_result got=%h exp=2a", alu_result_m); end
      n_checks++; if (write_data_m !== 32'd22) begin n_fail++; $display("FAIL stall_store got=%h exp=16", write_data_m); end
      tick();
      n_checks++; if (mem_write_m !== 1'b0) begin n_fail++; $display("FAIL stall_once got=%b exp=0", mem_write_m); end
   endtask

   task automatic test_flush();
      set_d(32'd1, 32'd2, '0, 5'd9, 3'b010, 1'b0, 1'b1, 1'b0);
      tick();
      flush_e = 1'b1; stall_e = 1'b1;
      set_nop();
      tick();
      flush_e = 1'b0; stall_e = 1'b0;
      n_checks++; if (reg_write_m !== 1'b0) begin n_fail++; $display("FAIL flush_stall_bubble got=%b exp=0", reg_write_m); end
      tick();
      n_checks++; if (reg_write_m !== 1'b0) begin n_fail++; $display("FAIL flush_stall_squash got=%b exp=0", reg_write_m); end
      set_d(32'd6, 32'd6, '0, 5'd4, 3'b010, 1'b0, 1'b1, 1'b0);
      tick();
      flush_e = 1'b1;
      set_d(32'd3, 32'd3, '0, 5'd11, 3'b010, 1'b0, 1'b1, 1'b1);
      tick();
      flush_e = 1'b0;
      set_nop();
      n_checks++; if ({reg_write_m, rd_m, alu_result_m} !== {1'b1, 5'd4, 32'd12}) begin n_fail++; $display("FAIL flush_advance got=%b/%0d/%h exp=1/4/c", reg_write_m, rd_m, alu_result_m); end
      tick();
      n_checks++; if ({reg_write_m, mem_write_m} !== 2'b00) begin n_fail++; $display("FAIL flush_squash got=%b exp=00", {reg_write_m, mem_write_m}); end
   endtask

   task automatic test_async_reset();
      set_d(32'd50, 32'd5, '0, 5'd12, 3'b110, 1'b0, 1'b1, 1'b1);
      tick();
      tick();
      n_checks++; if (alu_result_m !== 32'd45) begin n_fail++; $display("FAIL pre_reset_result got=%h exp=2d", alu_result_m); end
      #2;
      reset = 1'b1;
      #1;
      model_clear();
      n_checks++; if ({alu_result_m, write_data_m, rd_m, reg_write_m, mem_write_m} !== '0) begin n_fail++; $display("FAIL async_reset got=%h/%h/%0d/%b/%b exp=0", alu_result_m, write_data_m, rd_m, reg_write_m, mem_write_m); end
      n_checks++; if (zero_e !== 1'b1) begin n_fail++; $display("FAIL async_reset_zero got=%b exp=1", zero_e); end
      #2;
      reset = 1'b0;
      set_d(32'd2, 32'd9, '0, 5'd13, 3'b111, 1'b0, 1'b1, 1'b0);
      tick();
      set_nop();
      tick();
      n_checks++; if ({reg_write_m, rd_m, alu_result_m} !== {1'b1, 5'd13, 32'd1}) begin n_fail++; $display("FAIL post_reset_load got=%b/%0d/%h exp=1/13/1", reg_write_m, rd_m, alu_result_m); end
   endtask

   task automatic test_random();
      logic [31:0] exp_alu;
      for (int i = 0; i < 400; i++) begin
         stall_e     = ($urandom_range(0, 7) == 0);
         flush_e     = ($urandom_range(0, 7) == 0);
         forward_a_e = 2'($urandom_range(0, 3));
         forward_b_e = 2'($urandom_range(0, 3));
         result_w    = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
         set_d(($urandom_range(0, 3) == 0) ? 32'd0 : $urandom,
               ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom,
               ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 15)) : $urandom,
               5'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
         #1;
         exp_alu = model_alu();
         n_checks++; if (zero_e !== (exp_alu == 32'd0)) begin n_fail++; $display("FAIL rand_zero[%0d] got=%b exp=%b", i, zero_e, (exp_alu == 32'd0)); end
         tick();
         n_checks++; if ({alu_result_m, write_data_m, rd_m, reg_write_m, mem_write_m} !== {m_res, m_wd, m_rd, m_rw, m_mw})
            begin n_fail++; $display("FAIL rand_exmem[%0d] got=%h/%h/%0d/%b/%b exp=%h/%h/%0d/%b/%b", i, alu_result_m, write_data_m, rd_m, reg_write_m, mem_write_m, m_res, m_wd, m_rd, m_rw, m_mw); end
      end
      stall_e = 1'b0; flush_e = 1'b0; forward_a_e = 2'b00; forward_b_e = 2'b00;
   endtask

   initial begin
      test_reset();
      test_sub();
      test_logic();
      test_forward();
      test_stall();
      test_flush();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Guard against a hung run
   initial begin
      #200000;
      $display("FAIL timeout simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
